player_level_tracker: RTL and testbench



---
 rtl/player_level_tracker.sv | 190 +++++++++++++++++++
 tb/tb_player_level_tracker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_level_tracker.sv
// player_level_tracker
// Per-character progress tracker (one instance each for Mario and Luigi).
// Owns the character's level number and life counter, follows the shared
// level number produced by the level-combining logic, and sequences the
// IDLE -> PLAY -> DYING -> PLAY / OUT life cycle on frame ticks.
//
// Optional feature: define EXTRA_LIFE_EN to add the extra_life input, which
// grants one life (saturating at 3) while in PLAY or DYING.
module player_level_tracker #(
    parameter int START_LIVES    = 3,
    parameter int RESPAWN_FRAMES = 60,
    parameter int LAST_LEVEL     = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       start_game,
    input  logic       death_event,
    input  logic       exit_event,
`ifdef EXTRA_LIFE_EN
    input  logic       extra_life,
`endif
    input  logic [2:0] shared_level_num,
    output logic [2:0] level_num,
    output logic [1:0] life_counter,
    output logic       alive,
    output logic       respawning,
    output logic       game_over,
    output logic       level_done
);

    localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_DYING = 2'b10;
    localparam logic [1:0] ST_OUT   = 2'b11;

    localparam logic [1:0]       START_LIVES_C = 2'(START_LIVES);
    localparam logic [2:0]       LAST_LEVEL_C  = 3'(LAST_LEVEL);
    localparam logic [CNT_W-1:0] RESPAWN_C     = CNT_W'(RESPAWN_FRAMES);

    // Saturating life increment; the counter never wraps past 3.
    function automatic logic [1:0] lives_sat_inc(input logic [1:0] lives);
        if (lives == 2'd3) begin
            lives_sat_inc = 2'd3;
        end else begin
            lives_sat_inc = lives + 2'd1;
        end
    endfunction

    logic [1:0]       state_q,  state_d;
    logic [2:0]       level_q,  level_d;
    logic [1:0]       lives_q,  lives_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             done_d;
    logic             alive_q, respawning_q, game_over_q, done_q;

    logic             follow_s;
    logic             extra_s;
    logic [1:0]       lives_dec_s;
    logic [CNT_W-1:0] cnt_inc_s;

`ifdef EXTRA_LIFE_EN
    assign extra_s = extra_life;
`else
    assign extra_s = 1'b0;
`endif

    assign follow_s    = (shared_level_num > level_q);
    assign lives_dec_s = lives_q - 2'd1;
    assign cnt_inc_s   = cnt_q + CNT_W'(1);

    // Next-state logic: start_game first, then per-state event priority.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (start_game) begin
            state_d = ST_PLAY;
            level_d = 3'd1;
            lives_d = START_LIVES_C;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    level_d = 3'd0;
                end
                ST_PLAY: begin
                    if (death_event) begin
                        if (extra_s) begin
                            // Gain and loss cancel; the character keeps playing.
                            lives_d = lives_q;
                        end else if (lives_dec_s != 2'd0) begin
                            lives_d = lives_dec_s;
                            state_d = ST_DYING;
                            cnt_d   = '0;
                        end else begin
                            lives_d = 2'd0;
                            state_d = ST_OUT;
                        end
                    end else begin
                        if (extra_s) begin
                            lives_d = lives_sat_inc(lives_q);
                        end else begin
                            lives_d = lives_q;
                        end
                        if (exit_event) begin
                            if (level_q < LAST_LEVEL_C) begin
                                level_d = level_q + 3'd1;
                            end else begin
                                level_d = level_q;
                                done_d  = 1'b1;
                            end
                        end else if (follow_s) begin
                            level_d = shared_level_num;
                        end else begin
                            level_d = level_q;
                        end
                    end
                end
                ST_DYING: begin
                    if (extra_s) begin
                        lives_d = lives_sat_inc(lives_q);
                    end else begin
                        lives_d = lives_q;
                    end
                    if (follow_s) begin
                        level_d = shared_level_num;
                    end else begin
                        level_d = level_q;
                    end
                    if (frame_tick) begin
                        if (cnt_inc_s == RESPAWN_C) begin
                            state_d = ST_PLAY;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_inc_s;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_OUT: begin
                    level_d = level_q;
                    lives_d = 2'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = 3'd0;
                    lives_d = START_LIVES_C;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            level_q      <= 3'd0;
            lives_q      <= START_LIVES_C;
            cnt_q        <= '0;
            alive_q      <= 1'b0;
            respawning_q <= 1'b0;
            game_over_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            cnt_q        <= cnt_d;
            alive_q      <= (state_d == ST_PLAY);
            respawning_q <= (state_d == ST_DYING);
            game_over_q  <= (state_d == ST_OUT);
            done_q       <= done_d;
        end
    end

    assign level_num    = level_q;
    assign life_counter = lives_q;
    assign alive        = alive_q;
    assign respawning   = respawning_q;
    assign game_over    = game_over_q;
    assign level_done   = done_q;

endmodule

// File: tb/tb_player_level_tracker.sv
// Directed testbench for player_level_tracker (default parameters).
module tb_player_level_tracker;

    localparam int RESP = 60;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       start_game;
    logic       death_event;
    logic       exit_event;
    logic       extra_life;
    logic [2:0] shared_level;
    logic [2:0] level_num;
    logic [1:0] life_counter;
    logic       alive;
    logic       respawning;
    logic       game_over;
    logic       level_done;

    int n_checks;
    int n_fail;

    player_level_tracker dut (
        .Clk              (clk),
        .Reset            (rst_n),
        .frame_tick       (frame_tick),
        .start_game       (start_game),
        .death_event      (death_event),
        .exit_event       (exit_event),
`ifdef EXTRA_LIFE_EN
        .extra_life       (extra_life),
`endif
        .shared_level_num (shared_level),
        .level_num        (level_num),
        .life_counter     (life_counter),
        .alive            (alive),
        .respawning       (respawning),
        .game_over        (game_over),
        .level_done       (level_done)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then drop all pulse inputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        frame_tick  = 1'b0;
        start_game  = 1'b0;
        death_event = 1'b0;
        exit_event  = 1'b0;
        extra_life  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_level"},      32'(level_num),    32'd0);
        check_eq({tag, "_lives"},      32'(life_counter), 32'd3);
        check_eq({tag, "_alive"},      32'(alive),        32'd0);
        check_eq({tag, "_respawning"}, 32'(respawning),   32'd0);
        check_eq({tag, "_game_over"},  32'(game_over),    32'd0);
        check_eq({tag, "_level_done"}, 32'(level_done),   32'd0);
    endtask

    // Run the full respawn: RESP-1 ticks keep DYING, the last returns to PLAY.
    task automatic respawn(input string tag);
        for (int i = 0; i < RESP - 1; i++) begin
            frame_tick = 1'b1;
            step();
            step();
        end
        check_eq({tag, "_still_dying"}, 32'(respawning), 32'd1);
        frame_tick = 1'b1;
        step();
        check_eq({tag, "_alive"},  32'(alive),      32'd1);
        check_eq({tag, "_not_dy"}, 32'(respawning), 32'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        frame_tick   = 1'b0;
        start_game   = 1'b0;
        death_event  = 1'b0;
        exit_event   = 1'b0;
        extra_life   = 1'b0;
        shared_level = 3'd0;
        #12;
        check_reset_values("reset");
        rst_n = 1'b1;
        step();
        check_eq("idle_level", 32'(level_num), 32'd0);

        // Start the game.
        start_game = 1'b1;
        step();
        check_eq("start_level", 32'(level_num),    32'd1);
        check_eq("start_lives", 32'(life_counter), 32'd3);
        check_eq("start_alive", 32'(alive),        32'd1);

        // Three exits: 2, 3, then 3 held with a one-cycle level_done.
        exit_event = 1'b1;
        step();
        check_eq("exit1_level", 32'(level_num),  32'd2);
        check_eq("exit1_done",  32'(level_done), 32'd0);
        exit_event = 1'b1;
        step();
        check_eq("exit2_level", 32'(level_num),  32'd3);
        exit_event = 1'b1;
        step();
        check_eq("exit3_level", 32'(level_num),  32'd3);
        check_eq("exit3_done",  32'(level_done), 32'd1);
        step();
        check_eq("done_pulse_end", 32'(level_done), 32'd0);

        // Restart from PLAY, then exit beats follow in the same cycle.
        start_game = 1'b1;
        step();
        check_eq("restart_level", 32'(level_num), 32'd1);
        shared_level = 3'd3;
        exit_event   = 1'b1;
        step();
        check_eq("exit_over_follow", 32'(level_num), 32'd2);
        step();
        check_eq("follow_to_3", 32'(level_num), 32'd3);
        shared_level = 3'd0;

        // Follow rule: up to 2, never down to 1.
        start_game = 1'b1;
        step();
        shared_level = 3'd2;
        step();
        check_eq("follow_up", 32'(level_num), 32'd2);
        shared_level = 3'd1;
        step();
        check_eq("follow_no_down", 32'(level_num), 32'd2);
        shared_level = 3'd0;

        // Simultaneous death and exit: death wins.
        death_event = 1'b1;
        exit_event  = 1'b1;
        step();
        check_eq("dx_lives",      32'(life_counter), 32'd2);
        check_eq("dx_level",      32'(level_num),    32'd2);
        check_eq("dx_respawning", 32'(respawning),   32'd1);
        check_eq("dx_alive",      32'(alive),        32'd0);
        death_event = 1'b1;
        step();
        check_eq("dying_ignores_death", 32'(life_counter), 32'd2);
        respawn("resp1");
        check_eq("resp1_level", 32'(level_num), 32'd2);

        // Lose the remaining lives.
        death_event = 1'b1;
        step();
        check_eq("death2_lives", 32'(life_counter), 32'd1);
        respawn("resp2");
        death_event = 1'b1;
        step();
        check_eq("out_game_over", 32'(game_over),    32'd1);
        check_eq("out_lives",     32'(life_counter), 32'd0);
        check_eq("out_alive",     32'(alive),        32'd0);
        shared_level = 3'd3;
        exit_event   = 1'b1;
        step();
        step();
        check_eq("out_level_held", 32'(level_num), 32'd2);
        check_eq("out_still_over", 32'(game_over), 32'd1);
        shared_level = 3'd0;
        start_game   = 1'b1;
        step();
        check_eq("out_restart_alive", 32'(alive),        32'd1);
        check_eq("out_restart_lives", 32'(life_counter), 32'd3);
        check_eq("out_restart_level", 32'(level_num),    32'd1);
        check_eq("out_restart_go",    32'(game_over),    32'd0);

        // Follow while dying, then reset in the middle of the respawn.
        death_event = 1'b1;
        step();
        shared_level = 3'd2;
        step();
        check_eq("dying_follow", 32'(level_num), 32'd2);
        shared_level = 3'd0;
        for (int i = 0; i < 30; i++) begin
            frame_tick = 1'b1;
            step();
        end
        check_eq("mid_dying", 32'(respawning), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        #2;
        rst_n = 1'b1;
        step();
        check_eq("post_reset_idle", 32'(alive), 32'd0);

`ifdef EXTRA_LIFE_EN
        start_game = 1'b1;
        step();
        extra_life = 1'b1;
        step();
        check_eq("extra_sat", 32'(life_counter), 32'd3);
        death_event = 1'b1;
        step();
        check_eq("extra_death_lives", 32'(life_counter), 32'd2);
        extra_life = 1'b1;
        step();
        check_eq("extra_inc", 32'(life_counter), 32'd3);
        respawn("resp_extra");
        death_event = 1'b1;
        extra_life  = 1'b1;
        step();
        check_eq("extra_cancel_lives", 32'(life_counter), 32'd3);
        check_eq("extra_cancel_alive", 32'(alive),        32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
